bnn_seq_classifier: RTL and testbench

BNN_SEQ_CLASSIFIER -- requirements
Module: bnn_seq_classifier

---
 rtl/bnn_pkg.sv | 29 ++
 rtl/bnn_xnor_popcount.sv | 21 ++
 rtl/bnn_seq_classifier.sv | 182 ++++++++++++++++++
 tb/tb_bnn_seq_classifier.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared types and width helpers for the sequential binary neural network
// classifier.
package bnn_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HID,
        S_OUT,
        S_DONE
    } state_e;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Feature is "on" when it sits in the upper half of its unsigned range.
    function automatic logic binarise(input logic [31:0] v, input int w);
        return v >= (32'd1 << (w - 1));
    endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Counts matching bit positions between two binary vectors.
module bnn_xnor_popcount
    import bnn_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0]          a,
    input  logic [W-1:0]          b,
    output logic [cnt_w(W)-1:0]   count
);

    localparam int CW = cnt_w(W);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(~(a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/bnn_seq_classifier.sv
// Two-layer binary network evaluated one neuron per cycle, with a
// serially loaded weight image and argmax over class scores.
module bnn_seq_classifier
    import bnn_pkg::*;
#(
    parameter int N_FEAT = 4,
    parameter int FEAT_W = 4,
    parameter int N_HID  = 4,
    parameter int N_CLS  = 2,
    parameter int BIAS_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [N_FEAT*FEAT_W-1:0]   feat_in,
    input  logic                       cfg_shift,
    input  logic                       cfg_bit,
    output logic                       busy,
    output logic                       valid,
    output logic [idx_w(N_CLS)-1:0]    class_out,
    output logic [cnt_w(N_HID)-1:0]    score_out,
    output logic [N_HID-1:0]           hidden_out,
    output logic                       cfg_err
);

    localparam int WL     = N_HID*BIAS_W + N_CLS*N_HID + N_HID*N_FEAT;
    localparam int HO_OFF = N_HID*BIAS_W;
    localparam int HI_OFF = HO_OFF + N_CLS*N_HID;
    localparam int FC_W   = cnt_w(N_FEAT);
    localparam int SC_W   = cnt_w(N_HID);
    localparam int CL_W   = idx_w(N_CLS);
    localparam int IX_W   = idx_w(max_i(N_HID, N_CLS));
    localparam int SUM_W  = max_i(FC_W, BIAS_W) + 2;

    state_e            state_q, state_d;
    logic [WL-1:0]     img_q, img_d;
    logic [N_FEAT-1:0] x_q, x_d;
    logic [N_HID-1:0]  hid_q, hid_d;
    logic [IX_W-1:0]   idx_q, idx_d;
    logic [SC_W-1:0]   best_q, best_d;
    logic [CL_W-1:0]   bcls_q, bcls_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [CL_W-1:0]   cls_q, cls_d;
    logic [SC_W-1:0]   score_q, score_d;
    logic [N_HID-1:0]  hout_q, hout_d;
    logic              err_q, err_d;

    logic [N_FEAT-1:0] wih_row;
    logic [N_HID-1:0]  who_row;
    logic [BIAS_W-1:0] bias;
    logic [FC_W-1:0]   fcnt;
    logic [SC_W-1:0]   ocnt;
    logic [SUM_W-1:0]  sum;
    logic              fire;

    // One shared counter selects the active neuron or class row.
    assign wih_row = img_q[HI_OFF + int'(idx_q)*N_FEAT +: N_FEAT];
    assign who_row = img_q[HO_OFF + int'(idx_q)*N_HID +: N_HID];
    assign bias    = img_q[int'(idx_q)*BIAS_W +: BIAS_W];

    bnn_xnor_popcount #(.W(N_FEAT)) u_hid_pc (
        .a     (x_q),
        .b     (wih_row),
        .count (fcnt)
    );

    bnn_xnor_popcount #(.W(N_HID)) u_out_pc (
        .a     (hid_q),
        .b     (who_row),
        .count (ocnt)
    );

    assign sum  = SUM_W'(fcnt)
                + {{(SUM_W-BIAS_W){bias[BIAS_W-1]}}, bias}
                - SUM_W'(N_FEAT/2);
    assign fire = ~sum[SUM_W-1];

    always_comb begin
        state_d = state_q;
        img_d   = img_q;
        x_d     = x_q;
        hid_d   = hid_q;
        idx_d   = idx_q;
        best_d  = best_q;
        bcls_d  = bcls_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        cls_d   = cls_q;
        score_d = score_q;
        hout_d  = hout_q;
        err_d   = err_q | (cfg_shift & ((state_q != S_IDLE) | start));
        if (cfg_shift && state_q == S_IDLE && !start) begin
            img_d = {img_q[WL-2:0], cfg_bit};
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HID;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    for (int i = 0; i < N_FEAT; i++) begin
                        x_d[i] = binarise(32'(feat_in[i*FEAT_W +: FEAT_W]), FEAT_W);
                    end
                end
            end
            S_HID: begin
                for (int j = 0; j < N_HID; j++) begin
                    if (int'(idx_q) == j) hid_d[j] = fire;
                end
                if (int'(idx_q) == N_HID - 1) begin
                    state_d = S_OUT;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IX_W'(1);
                end
            end
            S_OUT: begin
                // Strictly-greater update keeps the lowest index on ties.
                if (idx_q == '0 || ocnt > best_q) begin
                    best_d = ocnt;
                    bcls_d = CL_W'(idx_q);
                end
                if (int'(idx_q) == N_CLS - 1) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IX_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b1;
                hout_d  = hid_q;
                score_d = best_q;
                cls_d   = bcls_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            img_q   <= '0;
            x_q     <= '0;
            hid_q   <= '0;
            idx_q   <= '0;
            best_q  <= '0;
            bcls_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            cls_q   <= '0;
            score_q <= '0;
            hout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            img_q   <= img_d;
            x_q     <= x_d;
            hid_q   <= hid_d;
            idx_q   <= idx_d;
            best_q  <= best_d;
            bcls_q  <= bcls_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            cls_q   <= cls_d;
            score_q <= score_d;
            hout_q  <= hout_d;
            err_q   <= err_d;
        end
    end

    assign busy       = busy_q;
    assign valid      = valid_q;
    assign class_out  = cls_q;
    assign score_out  = score_q;
    assign hidden_out = hout_q;
    assign cfg_err    = err_q;

endmodule

// File: tb/tb_bnn_seq_classifier.sv
// Scoreboard bench for bnn_seq_classifier: stimulus pushes expected
// results, a negedge monitor pops them when valid is seen.
module tb_bnn_seq_classifier;

    localparam int N_FEAT = 4;
    localparam int FEAT_W = 4;
    localparam int N_HID  = 4;
    localparam int N_CLS  = 2;
    localparam int BIAS_W = 4;
    localparam int WL     = N_HID*BIAS_W + N_CLS*N_HID + N_HID*N_FEAT;
    localparam int HO     = N_HID*BIAS_W;
    localparam int HI     = HO + N_CLS*N_HID;
    localparam int LAT    = N_HID + N_CLS + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] feat_in;
    logic        cfg_shift;
    logic        cfg_bit;
    logic        busy;
    logic        valid;
    logic [0:0]  class_out;
    logic [2:0]  score_out;
    logic [3:0]  hidden_out;
    logic        cfg_err;

    bnn_seq_classifier #(
        .N_FEAT (N_FEAT),
        .FEAT_W (FEAT_W),
        .N_HID  (N_HID),
        .N_CLS  (N_CLS),
        .BIAS_W (BIAS_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .feat_in    (feat_in),
        .cfg_shift  (cfg_shift),
        .cfg_bit    (cfg_bit),
        .busy       (busy),
        .valid      (valid),
        .class_out  (class_out),
        .score_out  (score_out),
        .hidden_out (hidden_out),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hid;
        int cls;
        int score;
        int cyc;
    } exp_t;

    exp_t          q[$];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    logic [WL-1:0] img_m;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain arithmetic over the weight image fields.
    function automatic exp_t model(input logic [WL-1:0] img, input logic [15:0] f);
        exp_t e;
        int x[N_FEAT];
        int h[N_HID];
        int pc, b, s, best;
        for (int i = 0; i < N_FEAT; i++) x[i] = (int'(f[i*FEAT_W +: FEAT_W]) >= 8) ? 1 : 0;
        e.hid = 0;
        for (int j = 0; j < N_HID; j++) begin
            pc = 0;
            for (int i = 0; i < N_FEAT; i++)
                if (x[i] == int'(img[HI + j*N_FEAT + i])) pc++;
            b = int'(img[j*BIAS_W +: BIAS_W]);
            if (b >= 8) b -= 16;
            h[j] = (pc + b - N_FEAT/2 >= 0) ? 1 : 0;
            e.hid = e.hid | (h[j] << j);
        end
        best = -1;
        e.cls = 0;
        for (int c = 0; c < N_CLS; c++) begin
            s = 0;
            for (int k = 0; k < N_HID; k++)
                if (h[k] == int'(img[HO + c*N_HID + k])) s++;
            if (s > best) begin
                best = s;
                e.cls = c;
            end
        end
        e.score = best;
        e.cyc = 0;
        return e;
    endfunction

    function automatic exp_t mk(input int hid, input int cls, input int score);
        exp_t e;
        e.hid = hid;
        e.cls = cls;
        e.score = score;
        e.cyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: valid=1 with nothing pending (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                check("valid_cycle", cyc, e.cyc);
                check("hidden_out", int'(hidden_out), e.hid);
                check("class_out", int'(class_out), e.cls);
                check("score_out", int'(score_out), e.score);
                check("busy_at_valid", int'(busy), 0);
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_valid"}, int'(valid), 0);
        check({tag, "_class"}, int'(class_out), 0);
        check({tag, "_score"}, int'(score_out), 0);
        check({tag, "_hidden"}, int'(hidden_out), 0);
        check({tag, "_cfg_err"}, int'(cfg_err), 0);
    endtask

    // Called at a negedge; asserts rst mid-low-phase and checks at once.
    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        start = 1'b0;
        cfg_shift = 1'b0;
        #1 check_zero_outputs(tag);
        q.delete();
        img_m = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_image(input logic [WL-1:0] img);
        for (int i = WL - 1; i >= 0; i--) begin
            cfg_shift = 1'b1;
            cfg_bit = img[i];
            @(negedge clk);
        end
        cfg_shift = 1'b0;
        cfg_bit = 1'b0;
        img_m = img;
    endtask

    task automatic issue(input logic [15:0] f, input exp_t e);
        exp_t t;
        t = e;
        feat_in = f;
        start = 1'b1;
        t.cyc = cyc + 1 + LAT;
        q.push_back(t);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        check("done_in_time", q.size(), 0);
        q.delete();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [WL-1:0] img;
        logic [15:0]   f;
        exp_t          e;
        int            n;
        rst = 1'b1;
        start = 1'b0;
        feat_in = '0;
        cfg_shift = 1'b0;
        cfg_bit = 1'b0;
        img_m = '0;
        #1 check_zero_outputs("por");
        @(negedge clk);
        rst = 1'b0;

        // Zero image, start on first edge after reset release.
        issue(16'h0000, mk(15, 0, 0));
        wait_done();

        // Hand-computed image.
        img = '0;
        img[HI + 0 +: 4] = 4'b1001;
        img[HI + 4 +: 4] = 4'b1011;
        img[HI + 8 +: 4] = 4'b1100;
        img[HI + 12 +: 4] = 4'b1110;
        img[HO + 0 +: 4] = 4'b1010;
        img[HO + 4 +: 4] = 4'b0101;
        img[0 +: 4] = 4'd1;
        img[4 +: 4] = 4'd1;
        img[8 +: 4] = 4'hF;
        img[12 +: 4] = 4'd1;
        load_image(img);
        issue(16'h0000, mk(11, 0, 3));
        wait_done();
        issue(16'hFFFF, mk(11, 0, 3));
        wait_done();
        check("cfg_err_clean", int'(cfg_err), 0);

        // Start while busy and cfg_shift mid-run are both ignored.
        feat_in = 16'h0000;
        start = 1'b1;
        e = mk(11, 0, 3);
        e.cyc = cyc + 1 + LAT;
        q.push_back(e);
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        cfg_shift = 1'b1;
        cfg_bit = 1'b1;
        @(negedge clk);
        cfg_shift = 1'b0;
        wait_done();
        check("cfg_err_busy", int'(cfg_err), 1);
        issue(16'h0000, mk(11, 0, 3));
        wait_done();

        // Reset in the middle of a run.
        issue(16'hFFFF, mk(11, 0, 3));
        repeat (3) @(negedge clk);
        do_reset("midrun");
        issue(16'h0000, mk(15, 0, 0));
        wait_done();

        // Back-to-back runs with start held high.
        img = WL'({$urandom, $urandom});
        load_image(img);
        f = 16'($urandom);
        e = model(img_m, f);
        feat_in = f;
        start = 1'b1;
        n = cyc;
        for (int k = 0; k < 3; k++) begin
            e.cyc = n + 1 + LAT + k*(LAT + 1);
            q.push_back(e);
        end
        repeat (17) @(negedge clk);
        start = 1'b0;
        wait_done();

        // Random images and features against the reference model.
        for (int r = 0; r < 6; r++) begin
            img = WL'({$urandom, $urandom});
            load_image(img);
            for (int k = 0; k < 4; k++) begin
                f = 16'($urandom);
                issue(f, model(img_m, f));
                wait_done();
            end
        end
        check("cfg_err_before_coincident", int'(cfg_err), 0);

        // cfg_shift coincident with an accepted start.
        f = 16'($urandom);
        feat_in = f;
        start = 1'b1;
        cfg_shift = 1'b1;
        cfg_bit = ~img_m[WL-1];
        e = model(img_m, f);
        e.cyc = cyc + 1 + LAT;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        cfg_shift = 1'b0;
        wait_done();
        check("cfg_err_coincident", int'(cfg_err), 1);
        f = 16'($urandom);
        issue(f, model(img_m, f));
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
